// File: rtl/gray_counter_pkg.sv
// Shared types for the Gray-coded up/down counter.
package gray_counter_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/gray_counter_b2g.sv
// Binary to reflected-Gray converter, purely combinational.
module binary_to_gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with separately registered binary and Gray outputs; gray_o
// is flop-driven so it can cross clock domains through a synchroniser.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int SATURATE = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [N-1:0] load_bin_i,
  input  logic         en_i,
  input  logic         down_i,
  output logic [N-1:0] bin_o,
  output logic [N-1:0] gray_o,
  output logic         wrap_o
);

  localparam mode_e        MODE  = (SATURATE != 0) ? SAT : WRAP;
  localparam logic [N-1:0] MAX_V = '1;
  localparam logic [N-1:0] ZERO  = '0;
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

  if (N < 2) begin : g_bad_width
    $error("gray_counter: N must be at least 2");
  end

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;
  logic         at_bound;

  assign at_bound = down_i ? (bin_q == ZERO) : (bin_q == MAX_V);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      bin_d = ZERO;
    end else if (load_i) begin
      bin_d = load_bin_i;
    end else if (en_i) begin
      wrap_d = at_bound;
      // In saturate mode a step past the bound is blocked but still flagged.
      if (!(at_bound && MODE == SAT)) begin
        bin_d = down_i ? (bin_q - ONE) : (bin_q + ONE);
      end
    end
  end

  // Gray is taken from the next binary value so both banks update together.
  binary_to_gray #(.W(N)) u_b2g (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= ZERO;
      gray_q <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign wrap_o = wrap_q;

endmodule
